cipher_display_sequencer: RTL and testbench

//  Downstream consumer of the encryption stage: after the cipher bytes are written to the

---
 rtl/cipher_display_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_cipher_display_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_display_sequencer.sv
// cipher_display_sequencer
//   Reads cipher bytes back from a registered BRAM one at a time and converts
//   each byte to three BCD digits with a sequential double-dabble. Each byte
//   is shown on the seven-segment driver digits for DWELL cycles. A 16-LED
//   thermometer bar tracks progress, and done pulses after the last byte.
//
// Ports
//   CLK100MHZ          system clock (rising edge)
//   reset_n            asynchronous active-low reset
//   start              1-cycle run request, sampled only while idle
//   abort              synchronous stop back to idle, no done pulse
//   count              number of cipher bytes, latched on an accepted start
//   mem_en / mem_addr  BRAM read strobe and address (current byte index)
//   mem_dout           BRAM read data, valid one cycle after mem_en
//   busy / done        run in progress / one-cycle completion pulse
//   digit3             current byte index mod 10
//   digit2..digit0     hundreds / tens / units of the current cipher byte
//   led                progress thermometer
module cipher_display_sequencer #(
  parameter int DWELL  = 10000,
  parameter int ADDR_W = 8
) (
  input  logic              CLK100MHZ,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] count,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_dout,
  output logic              busy,
  output logic              done,
  output logic [3:0]        digit3,
  output logic [3:0]        digit2,
  output logic [3:0]        digit1,
  output logic [3:0]        digit0,
  output logic [15:0]       led
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  // Wide enough for 16 * (2^ADDR_W - 1) so the thermometer compare never overflows.
  localparam int LW   = ADDR_W + 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CONV,
    S_SHOW,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [2:0]        conv_q, conv_d;
  logic [7:0]        sr_q, sr_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [3:0]        dig3_q, dig3_d;
  logic [3:0]        dig2_q, dig2_d;
  logic [3:0]        dig1_q, dig1_d;
  logic [3:0]        dig0_q, dig0_d;
  logic [15:0]       led_q, led_d;
  logic [19:0]       step_c;

  // One double-dabble iteration on {bcd, binary}: correct any BCD nibble
  // that would overflow past 9 after doubling, then shift left by one.
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] a;
    a = v;
    for (int n = 0; n < 3; n++) begin
      if (a[8+4*n +: 4] >= 4'd5) a[8+4*n +: 4] = a[8+4*n +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

  // led[k] lights once shown/total >= (k+1)/16, evaluated by cross-multiplying.
  function automatic logic [15:0] thermo(input logic [ADDR_W-1:0] shown,
                                         input logic [ADDR_W-1:0] total);
    logic [LW-1:0] lhs;
    logic [LW-1:0] rhs;
    logic [15:0]   t;
    lhs = LW'(shown) << 4;
    t   = '0;
    for (int k = 0; k < 16; k++) begin
      rhs  = LW'(k + 1) * LW'(total);
      t[k] = (lhs >= rhs);
    end
    return t;
  endfunction

  function automatic logic [3:0] mod10(input logic [ADDR_W-1:0] idx);
    int r;
    r = int'(idx) % 10;
    return 4'(r);
  endfunction

  assign step_c = dd_step({bcd_q, sr_q});

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = count_q;
    dwell_d = dwell_q;
    conv_d  = conv_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    dig3_d  = dig3_q;
    dig2_d  = dig2_q;
    dig1_d  = dig1_q;
    dig0_d  = dig0_q;
    led_d   = led_q;

    // Abort wins over everything else; digits and led are left untouched.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            count_d = count;
            index_d = '0;
            dwell_d = '0;
            led_d   = '0;
            state_d = (count == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: state_d = S_WAIT;
        S_WAIT: begin
          sr_d    = mem_dout;
          bcd_d   = '0;
          conv_d  = '0;
          state_d = S_CONV;
        end
        S_CONV: begin
          {bcd_d, sr_d} = step_c;
          conv_d        = conv_q + 3'd1;
          if (conv_q == 3'd7) begin
            dig2_d  = step_c[19:16];
            dig1_d  = step_c[15:12];
            dig0_d  = step_c[11:8];
            dig3_d  = mod10(index_q);
            dwell_d = '0;
            state_d = S_SHOW;
          end
        end
        S_SHOW: begin
          if (dwell_q == DW_W'(DWELL - 1)) begin
            dwell_d = '0;
            led_d   = thermo(index_q + ADDR_W'(1), count_q);
            if (index_q == count_q - ADDR_W'(1)) begin
              state_d = S_DONE;
            end else begin
              index_d = index_q + ADDR_W'(1);
              state_d = S_READ;
            end
          end else begin
            dwell_d = dwell_q + DW_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      index_q <= '0;
      count_q <= '0;
      dwell_q <= '0;
      conv_q  <= '0;
      sr_q    <= '0;
      bcd_q   <= '0;
      dig3_q  <= '0;
      dig2_q  <= '0;
      dig1_q  <= '0;
      dig0_q  <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      count_q <= count_d;
      dwell_q <= dwell_d;
      conv_q  <= conv_d;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
      dig3_q  <= dig3_d;
      dig2_q  <= dig2_d;
      dig1_q  <= dig1_d;
      dig0_q  <= dig0_d;
      led_q   <= led_d;
    end
  end

  assign mem_en   = (state_q == S_READ);
  assign mem_addr = index_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign digit3   = dig3_q;
  assign digit2   = dig2_q;
  assign digit1   = dig1_q;
  assign digit0   = dig0_q;
  assign led      = led_q;

endmodule

// File: tb/tb_cipher_display_sequencer.sv
// Directed bench for cipher_display_sequencer: one instance with DWELL=4 and
// one with DWELL=1, each fed by its own registered BRAM model.
module tb_cipher_display_sequencer;

  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start, abort, sel;
  logic [AW-1:0] count;
  logic          start4, start1, abort4, abort1;

  logic          en4, busy4, done4, en1, busy1, done1;
  logic [AW-1:0] addr4, addr1;
  logic [7:0]    dout4, dout1;
  logic [3:0]    d4_3, d4_2, d4_1, d4_0, d1_3, d1_2, d1_1, d1_0;
  logic [15:0]   led4, led1;

  logic [7:0]    mem [0:255];

  assign start4 = start & ~sel;
  assign start1 = start & sel;
  assign abort4 = abort & ~sel;
  assign abort1 = abort & sel;

  cipher_display_sequencer #(.DWELL(4), .ADDR_W(AW)) u_dut4 (
    .CLK100MHZ(clk), .reset_n(reset_n), .start(start4), .abort(abort4),
    .count(count), .mem_en(en4), .mem_addr(addr4), .mem_dout(dout4),
    .busy(busy4), .done(done4), .digit3(d4_3), .digit2(d4_2),
    .digit1(d4_1), .digit0(d4_0), .led(led4)
  );

  cipher_display_sequencer #(.DWELL(1), .ADDR_W(AW)) u_dut1 (
    .CLK100MHZ(clk), .reset_n(reset_n), .start(start1), .abort(abort1),
    .count(count), .mem_en(en1), .mem_addr(addr1), .mem_dout(dout1),
    .busy(busy1), .done(done1), .digit3(d1_3), .digit2(d1_2),
    .digit1(d1_1), .digit0(d1_0), .led(led1)
  );

  // Registered BRAM: data appears the cycle after the enable.
  always @(posedge clk) begin
    if (en4) dout4 <= mem[addr4];
    if (en1) dout1 <= mem[addr1];
  end

  wire          o_en   = sel ? en1   : en4;
  wire [AW-1:0] o_addr = sel ? addr1 : addr4;
  wire          o_busy = sel ? busy1 : busy4;
  wire          o_done = sel ? done1 : done4;
  wire [15:0]   o_led  = sel ? led1  : led4;
  wire [15:0]   o_dig  = sel ? {d1_3, d1_2, d1_1, d1_0} : {d4_3, d4_2, d4_1, d4_0};

  int          checks = 0;
  int          errors = 0;
  logic [15:0] prev_dig [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] dig_model(input int v, input int idx);
    return {4'(idx % 10), 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Number of lit LEDs is floor(16*shown/total).
  function automatic logic [15:0] exp_led(input int shown, input int n);
    int bits;
    if (n == 0) return 16'h0000;
    bits = (shown * 16) / n;
    if (bits > 16) bits = 16;
    return 16'((1 << bits) - 1);
  endfunction

  task automatic do_start(input int cnt);
    count = AW'(cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered in the READ cycle of byte 0; walks every byte cycle by cycle.
  task automatic run_check(input int n, input int dwell);
    logic [15:0] e;
    for (int b = 0; b < n; b++) begin
      check("mem_en_read", o_en, 1);
      check("mem_addr", o_addr, b);
      check("led_progress", o_led, exp_led(b, n));
      check("busy_run", o_busy, 1);
      tick();
      check("mem_en_wait", o_en, 0);
      repeat (8) tick();
      check("digits_hold", o_dig, prev_dig[sel]);
      tick();
      e = dig_model(int'(mem[b]), b);
      check("digits", o_dig, e);
      prev_dig[sel] = e;
      repeat (dwell) tick();
    end
    check("done_pulse", o_done, 1);
    check("led_full", o_led, 16'hFFFF);
    check("mem_en_done", o_en, 0);
    tick();
    check("done_clear", o_done, 0);
    check("busy_idle", o_busy, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    sel     = 1'b0;
    count   = '0;
    prev_dig[0] = '0;
    prev_dig[1] = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    repeat (3) tick();

    // Reset state
    check("rst_mem_en", en4, 0);
    check("rst_mem_addr", addr4, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_digits", {d4_3, d4_2, d4_1, d4_0}, 0);
    check("rst_led", led4, 0);
    check("rst_led_d1", led1, 0);
    reset_n = 1'b1;
    tick();

    // 1: bytes 0, 9, 255
    mem[0] = 8'd0; mem[1] = 8'd9; mem[2] = 8'd255;
    do_start(3);
    run_check(3, 4);

    // 2: first-byte latency with a nonzero byte
    mem[0] = 8'd123; mem[1] = 8'd45;
    check("idle_mem_en", o_en, 0);
    do_start(2);
    run_check(2, 4);

    // 3: DWELL=1 instance, thermometer steps
    sel = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 16 + 1);
    do_start(16);
    run_check(16, 1);
    mem[0] = 8'd7; mem[1] = 8'd80; mem[2] = 8'd200;
    do_start(3);
    run_check(3, 1);
    sel = 1'b0;

    // 4: count == 0
    do_start(0);
    check("cnt0_done", o_done, 1);
    check("cnt0_busy", o_busy, 1);
    check("cnt0_mem_en", o_en, 0);
    check("cnt0_led", o_led, 0);
    tick();
    check("cnt0_done_clr", o_done, 0);
    check("cnt0_busy_clr", o_busy, 0);
    check("cnt0_mem_en2", o_en, 0);

    // 5: start while busy ignored, abort in SHOW of byte 1
    mem[0] = 8'd0; mem[1] = 8'd9; mem[2] = 8'd255;
    do_start(3);
    start = 1'b1;
    count = 8'd7;
    tick();
    start = 1'b0;
    count = 8'd3;
    repeat (9) tick();
    check("abort_b0_dig", o_dig, 16'h0000);
    repeat (4) tick();
    check("abort_b1_addr", o_addr, 1);
    check("abort_b1_led", o_led, 16'h001F);
    repeat (10) tick();
    check("abort_b1_dig", o_dig, 16'h1009);
    tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    check("abort_mem_en", o_en, 0);
    check("abort_dig_hold", o_dig, 16'h1009);
    check("abort_led_hold", o_led, 16'h001F);
    repeat (3) begin
      tick();
      check("abort_no_done", o_done, 0);
      check("abort_stay_idle", o_busy, 0);
    end
    abort = 1'b1;
    start = 1'b1;
    count = 8'd3;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_start_idle", o_busy, 0);
    prev_dig[0] = 16'h1009;

    // 6: asynchronous reset during CONV, then a clean rerun
    do_start(3);
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy4, 0);
    check("arst_mem_en", en4, 0);
    check("arst_mem_addr", addr4, 0);
    check("arst_done", done4, 0);
    check("arst_digits", {d4_3, d4_2, d4_1, d4_0}, 0);
    check("arst_led", led4, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    prev_dig[0] = '0;
    do_start(3);
    run_check(3, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
